key_event_scheduler: RTL
========================

Name: key_event_scheduler

Overview:
- Shares NKEYS push-button inputs over one event channel with a valid/ready handshake.
- Each key gets a 2-flop synchronizer, a rising-edge press event and a press-and-hold auto-repeat timer.
- Events are queued one-deep per key and granted round-robin to the consumer, for example a menu or game FSM.
- Sits between the board KEY inputs (inverted at top level, active-high here) and the application control logic on CLOCK_50.

Parameters:
- NKEYS, 4, number of key inputs (2..8).
- HOLD_CYC, 25_000_000, cycles a key must stay high after its press event before the first repeat event.
- REP_CYC, 5_000_000, cycles between successive repeat events while the key stays held.
- KW, max(1,$clog2(NKEYS)), width of the key index (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- keys  in  NKEYS  raw active-high key levels, asynchronous to clk.
- evt_ready  in  1  consumer accepts the event this cycle.
- evt_valid  out  1  event presented on evt_key/evt_repeat.
- evt_key  out  KW  index of the key owning the presented event.
- evt_repeat  out  1  0 = initial press event, 1 = auto-repeat event.
- pending  out  NKEYS  per-key queued-event flags (status).
- overrun  out  1  sticky: an event was dropped because its key already had one queued.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (reset_n=0, async): sync flops, key FSMs, timers, pending, pending type bits, overrun, evt_valid, evt_key, evt_repeat all 0. RR pointer = 0 (key 0 highest priority first).
- Sync: key_s[i] = keys[i] through 2 flops. All logic below uses key_s.
- Per-key FSM, states IDLE, HOLD, REPEAT, one timer per key:
  - IDLE: key_s=1 -> emit press event, go to HOLD, timer=0.
  - HOLD: key_s=0 -> IDLE. Timer == HOLD_CYC-1 -> emit repeat event, go to REPEAT, timer=0. Otherwise timer++.
  - REPEAT: key_s=0 -> IDLE. Timer == REP_CYC-1 -> emit repeat event, timer=0. Otherwise timer++.
  - Net timing: if key_s rises in cycle t, press event fires at t, repeats fire at t+HOLD_CYC+k*REP_CYC (k>=0) while held.
  - Release in any cycle returns to IDLE with no event; a later press restarts timing from zero.
- Queue: an event in cycle t sets pending[i] and latches its type bit at the edge ending t.
- If pending[i] is already 1 and not being granted that cycle, the event is dropped, type is unchanged, and overrun is set.
- Output stage, registered. Loads when evt_valid=0 or (evt_valid & evt_ready):
  - Picks the first pending key at or after the RR pointer, wrapping.
  - Sets evt_valid=1, evt_key and evt_repeat from that key, clears its pending bit, and sets pointer = winner+1 mod NKEYS.
  - No key pending: evt_valid=0.
  - Minimum latency: event at t -> pending at t+1 -> evt_valid at t+2.
- Handshake: while evt_valid=1 and evt_ready=0, evt_key and evt_repeat are stable. Back-to-back accepts sustain one event per cycle.
- Simultaneous grant-clear and new event on the same key in one cycle: pending stays 1 with the new type, and no overrun.
- Overrun: overrun_clr has priority over a set in the same cycle.
- Timers saturate-free: width $clog2(max(HOLD_CYC,REP_CYC)), reset to 0 on every state change, so there is no wrap hazard.

Test Plan (NKEYS=4, HOLD_CYC=8, REP_CYC=4, evt_ready=1 unless stated):
- Single tap: keys[2] high 3 cycles -> exactly one event, evt_key=2, evt_repeat=0, first evt_valid 2 cycles after key_s rises. No further events.
- Hold: keys[1] held 20 cycles after key_s rises at t -> press at t, repeats at t+8, t+12, t+16, t+20 (all evt_repeat=1), each appearing on the channel 2 cycles later.
- Release at t+7: no repeat event. Re-press -> new press event, and the next repeat is again 8 cycles after the re-press.
- Round-robin: keys[0], keys[1] and keys[3] rise in the same cycle with evt_ready=1 -> grants in order 0,1,3 on consecutive cycles. Repeat with pointer=2 after a key-1 grant -> order 3,0.
- Backpressure: evt_ready=0 with key 0 presented; press key 0 again twice -> first extra press queues in pending[0], second sets overrun=1. evt_key held at 0. overrun_clr -> overrun=0.
- Async reset mid-hold: reset_n low for 1 cycle while key held in REPEAT -> all outputs 0 immediately. After release of reset with the key still high, a new press event fires (FSM restarts from IDLE).

Source files
------------

// File: rtl/key_event_scheduler_if.sv
// Event channel between the key scheduler and its consumer: valid/ready handshake
// carrying the owning key index and a press/repeat flag.
interface key_event_scheduler_if #(
  parameter int NKEYS = 4
);
  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;

  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_key;
  logic          evt_repeat;

  modport master (output evt_valid, evt_key, evt_repeat, input evt_ready);
  modport slave  (input evt_valid, evt_key, evt_repeat, output evt_ready);
endinterface

// File: rtl/key_event_scheduler.sv
// Synchronises NKEYS push buttons, generates press and auto-repeat events per key,
// queues them one-deep per key and grants them round-robin onto one event channel.
module key_event_scheduler #(
  parameter int NKEYS    = 4,
  parameter int HOLD_CYC = 25_000_000,
  parameter int REP_CYC  = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NKEYS-1:0]        keys,
  key_event_scheduler_if.master   evt,
  output logic [NKEYS-1:0]        pending,
  output logic                    overrun,
  input  logic                    overrun_clr
);
  localparam int KW   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int TMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [NKEYS-1:0] sync1, key_s;
  logic [1:0]       state [NKEYS];
  logic [TW-1:0]    timer [NKEYS];
  logic [NKEYS-1:0] ev, ev_rep, ptype, grant;
  logic [KW-1:0]    ptr, winner, idx;
  logic             found, load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      key_s <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking <= so every flop samples pre-edge values.
      sync1 <= keys;
      key_s <= sync1;
    end
  end

  // Event detection is purely a function of current state, timer and synchronised level.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a variable unassigned (no latch).
    ev     = '0;
    ev_rep = '0;
    for (int i = 0; i < NKEYS; i++) begin
      case (state[i])
        ST_IDLE:   ev[i] = key_s[i];
        ST_HOLD:   if (key_s[i] && timer[i] == TW'(HOLD_CYC - 1)) begin
                     ev[i]     = 1'b1;
                     ev_rep[i] = 1'b1;
                   end
        ST_REPEAT: if (key_s[i] && timer[i] == TW'(REP_CYC - 1)) begin
                     ev[i]     = 1'b1;
                     ev_rep[i] = 1'b1;
                   end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these arrays are small per-key flop banks, not RAM, so resetting them is cheap and required.
      for (int i = 0; i < NKEYS; i++) begin
        state[i] <= ST_IDLE;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        case (state[i])
          ST_IDLE: if (key_s[i]) begin
            state[i] <= ST_HOLD;
            timer[i] <= '0;
          end
          ST_HOLD: if (!key_s[i]) begin
            state[i] <= ST_IDLE;
            timer[i] <= '0;
          end else if (timer[i] == TW'(HOLD_CYC - 1)) begin
            state[i] <= ST_REPEAT;
            timer[i] <= '0;
          end else begin
            timer[i] <= timer[i] + 1'b1;
          end
          ST_REPEAT: if (!key_s[i]) begin
            state[i] <= ST_IDLE;
            timer[i] <= '0;
          end else if (timer[i] == TW'(REP_CYC - 1)) begin
            timer[i] <= '0;
          end else begin
            timer[i] <= timer[i] + 1'b1;
          end
          default: begin
            state[i] <= ST_IDLE;
            timer[i] <= '0;
          end
        endcase
      end
    end
  end

  // Round-robin: first pending key at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NKEYS; k++) begin
      idx = KW'((int'(ptr) + k) % NKEYS);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign load  = !evt.evt_valid || evt.evt_ready;
  assign grant = (load && found) ? (NKEYS'(1) << winner) : '0;

  // A key granted this cycle frees its slot, so a same-cycle event refills it instead of overrunning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      ptype   <= '0;
      overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (ev[i]) begin
          if (!pending[i] || grant[i]) begin
            pending[i] <= 1'b1;
            ptype[i]   <= ev_rep[i];
          end
        end else if (grant[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (overrun_clr)
        overrun <= 1'b0;
      else if (|(ev & pending & ~grant))
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt.evt_valid  <= 1'b0;
      evt.evt_key    <= '0;
      evt.evt_repeat <= 1'b0;
      ptr            <= '0;
    end else if (load) begin
      if (found) begin
        evt.evt_valid  <= 1'b1;
        evt.evt_key    <= winner;
        evt.evt_repeat <= ptype[winner];
        ptr            <= (winner == KW'(NKEYS - 1)) ? '0 : winner + 1'b1;
      end else begin
        evt.evt_valid  <= 1'b0;
      end
    end
  end
endmodule
